// File: rtl/l15_arb_pkg.sv
// Shared types for the L1.5 data RAM arbiter and its helpers.
// The localparams fix the default bank geometry; the RAM request struct
// is sized from them.
package l15_arb_pkg;

  localparam int unsigned L15_NB_RD_PORTS      = 4;
  localparam int unsigned L15_DATA_WIDTH       = 64;
  localparam int unsigned L15_ADDR_WIDTH       = 7;
  localparam int unsigned L15_BE_WIDTH         = L15_DATA_WIDTH / 8;
  localparam int unsigned L15_MAX_REFILL_BURST = 4;

  // Index width never collapses below one bit, even for a single reader.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned L15_RD_IDX_W = idx_width(L15_NB_RD_PORTS);

  typedef logic [L15_RD_IDX_W-1:0] rd_idx_t;

  typedef struct packed {
    logic                      req;
    logic                      write;
    logic [L15_ADDR_WIDTH-1:0] addr;
    logic [L15_DATA_WIDTH-1:0] wdata;
    logic [L15_BE_WIDTH-1:0]   be;
  } ram_req_t;

endpackage

// File: rtl/l15_rr_arbiter.sv
// Purely combinational round-robin arbiter: the pointer names the
// highest-priority requester, priority then falls through ascending
// indices with wrap-around.
module l15_rr_arbiter #(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic w_found;

  // Scan requesters starting at the pointer and pick the first one asserted.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && i_req[(32'(i_ptr) + i) % N]) begin
        w_found                      = 1'b1;
        o_gnt[(32'(i_ptr) + i) % N]  = 1'b1;
        o_idx                        = IDX_W'((32'(i_ptr) + i) % N);
      end
    end
    o_valid = w_found;
  end

endmodule

// File: rtl/l15_data_ram_arbiter.sv
// Shares one single-port L1.5 data SCM bank between NB_RD_PORTS fetch
// readers and the AXI refill writer. One grant per cycle, decided
// combinationally; read data returns one cycle after the grant.
// Optional macro L15_REFILL_FAIRNESS_EN: after MAX_REFILL_BURST back-to-back
// refill grants with a reader waiting, one read slot is forced.
module l15_data_ram_arbiter
  import l15_arb_pkg::*;
#(
  parameter int unsigned NB_RD_PORTS      = L15_NB_RD_PORTS,
  parameter int unsigned DATA_WIDTH       = L15_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH       = L15_ADDR_WIDTH,
  parameter int unsigned BE_WIDTH         = DATA_WIDTH / 8,
  parameter int unsigned MAX_REFILL_BURST = L15_MAX_REFILL_BURST
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  // fetch readers
  input  logic [NB_RD_PORTS-1:0]                rd_req_i,
  input  logic [NB_RD_PORTS-1:0][ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NB_RD_PORTS-1:0]                rd_gnt_o,
  output logic [NB_RD_PORTS-1:0]                rd_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 rd_rdata_o,
  // refill writer
  input  logic                                  refill_req_i,
  input  logic [ADDR_WIDTH-1:0]                 refill_addr_i,
  input  logic [DATA_WIDTH-1:0]                 refill_wdata_i,
  input  logic [BE_WIDTH-1:0]                   refill_be_i,
  output logic                                  refill_gnt_o,
  // data bank
  output logic                                  ram_req_o,
  output logic                                  ram_write_o,
  output logic [ADDR_WIDTH-1:0]                 ram_addr_o,
  output logic [DATA_WIDTH-1:0]                 ram_wdata_o,
  output logic [BE_WIDTH-1:0]                   ram_be_o,
  input  logic [DATA_WIDTH-1:0]                 ram_rdata_i
);

  rd_idx_t                rr_q;
  rd_idx_t                w_rr_next;
  logic [NB_RD_PORTS-1:0] rvalid_q;
  logic [NB_RD_PORTS-1:0] w_rr_gnt;
  rd_idx_t                w_rr_idx;
  logic                   w_rr_valid;
  logic                   w_any_rd;
  logic                   w_refill_win;
  logic                   w_rd_win;
  ram_req_t               w_ram;

  assign w_any_rd = |rd_req_i;

  l15_rr_arbiter #(
    .N (NB_RD_PORTS)
  ) u_rr_arbiter (
    .i_req   (rd_req_i),
    .i_ptr   (rr_q),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

`ifdef L15_REFILL_FAIRNESS_EN
  localparam int unsigned BURST_W = $clog2(MAX_REFILL_BURST + 1);

  logic [BURST_W-1:0] burst_cnt_q;
  logic               w_burst_full;

  assign w_burst_full = w_any_rd && (burst_cnt_q == BURST_W'(MAX_REFILL_BURST));
  assign w_refill_win = refill_req_i && !w_burst_full;

  // Count the current run of refill grants that kept a reader waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
    end else if (!w_any_rd || w_rd_win) begin
      burst_cnt_q <= '0;
    end else if (w_refill_win) begin
      burst_cnt_q <= burst_cnt_q + 1'b1;
    end
  end
`else
  // Refill has strict priority; readers may starve while it is held.
  assign w_refill_win = refill_req_i;
`endif

  assign w_rd_win     = w_rr_valid && !w_refill_win;
  assign rd_gnt_o     = w_rd_win ? w_rr_gnt : '0;
  assign refill_gnt_o = w_refill_win;

  // Drive the bank from whichever requester won; zeros when idle.
  always_comb begin
    w_ram = '0;
    if (w_refill_win) begin
      w_ram.req   = 1'b1;
      w_ram.write = 1'b1;
      w_ram.addr  = refill_addr_i;
      w_ram.wdata = refill_wdata_i;
      w_ram.be    = refill_be_i;
    end else if (w_rd_win) begin
      w_ram.req  = 1'b1;
      w_ram.addr = rd_addr_i[w_rr_idx];
      w_ram.be   = '1;
    end
  end

  assign ram_req_o   = w_ram.req;
  assign ram_write_o = w_ram.write;
  assign ram_addr_o  = w_ram.addr;
  assign ram_wdata_o = w_ram.wdata;
  assign ram_be_o    = w_ram.be;

  // Winner's successor becomes the new top-priority reader; wraps to 0.
  assign w_rr_next = (w_rr_idx == rd_idx_t'(NB_RD_PORTS - 1)) ? '0 : w_rr_idx + 1'b1;

  // Round-robin pointer and the one-cycle read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rvalid_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      rvalid_q <= rd_gnt_o;
      if (w_rd_win) begin
        rr_q <= w_rr_next;
      end
    end
  end

  assign rd_rvalid_o = rvalid_q;
  assign rd_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_l15_data_ram_arbiter.sv
// Self-checking bench for l15_data_ram_arbiter: a table of per-cycle vectors
// plus hand-written sequences for refill fairness and mid-flight reset.
// Build with +define+L15_REFILL_FAIRNESS_EN to check the fairness variant.
module tb_l15_data_ram_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        rd_req_i;
  logic [3:0][6:0]   rd_addr_i;
  logic [3:0]        rd_gnt_o;
  logic [3:0]        rd_rvalid_o;
  logic [63:0]       rd_rdata_o;
  logic              refill_req_i;
  logic [6:0]        refill_addr_i;
  logic [63:0]       refill_wdata_i;
  logic [7:0]        refill_be_i;
  logic              refill_gnt_o;
  logic              ram_req_o;
  logic              ram_write_o;
  logic [6:0]        ram_addr_o;
  logic [63:0]       ram_wdata_o;
  logic [7:0]        ram_be_o;
  logic [63:0]       ram_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l15_data_ram_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rd_req_i       (rd_req_i),
    .rd_addr_i      (rd_addr_i),
    .rd_gnt_o       (rd_gnt_o),
    .rd_rvalid_o    (rd_rvalid_o),
    .rd_rdata_o     (rd_rdata_o),
    .refill_req_i   (refill_req_i),
    .refill_addr_i  (refill_addr_i),
    .refill_wdata_i (refill_wdata_i),
    .refill_be_i    (refill_be_i),
    .refill_gnt_o   (refill_gnt_o),
    .ram_req_o      (ram_req_o),
    .ram_write_o    (ram_write_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o),
    .ram_be_o       (ram_be_o),
    .ram_rdata_i    (ram_rdata_i)
  );

  // Behavioural single-port bank: word i preloaded with DEADBEEF_<i>.
  logic [63:0] mem [128];
  logic [63:0] rdata_q;
  initial for (int i = 0; i < 128; i++) mem[i] = {32'hDEADBEEF, 32'(i)};

  always @(posedge clk) begin
    if (ram_req_o) begin
      if (ram_write_o) begin
        for (int b = 0; b < 8; b++)
          if (ram_be_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
      end else begin
        rdata_q <= mem[ram_addr_o];
      end
    end
  end
  assign ram_rdata_i = rdata_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]      rd_req;
    logic [3:0][6:0] addrs;
    logic            rf;
    logic [6:0]      rf_addr;
    logic [63:0]     rf_wdata;
    logic [7:0]      rf_be;
    logic [3:0]      exp_gnt;
    logic [3:0]      exp_rvalid;
    logic            chk_rdata;
    logic [63:0]     exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rq, input logic [3:0][6:0] ad,
                              input logic rf, input logic [6:0] rfa,
                              input logic [63:0] rfd, input logic [7:0] rfbe,
                              input logic [3:0] eg, input logic [3:0] erv,
                              input logic chk, input logic [63:0] erd);
    vec_t v;
    v.rd_req = rq; v.addrs = ad; v.rf = rf; v.rf_addr = rfa; v.rf_wdata = rfd;
    v.rf_be = rfbe; v.exp_gnt = eg; v.exp_rvalid = erv; v.chk_rdata = chk;
    v.exp_rdata = erd;
    return v;
  endfunction

  vec_t tbl [16];

  initial begin
    logic [3:0][6:0] a_rot;
    logic [6:0]      exp_addr;
    a_rot = {7'h23, 7'h22, 7'h21, 7'h20};

    // idle
    tbl[0]  = mk(4'b0000, '0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    // all readers from reset: grants rotate 0,1,2,3,0
    tbl[1]  = mk(4'b1111, a_rot, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
    tbl[2]  = mk(4'b1110, a_rot, 0, 0, 0, 0, 4'b0010, 4'b0001, 1, 64'hDEADBEEF_00000020);
    tbl[3]  = mk(4'b1101, a_rot, 0, 0, 0, 0, 4'b0100, 4'b0010, 1, 64'hDEADBEEF_00000021);
    tbl[4]  = mk(4'b1001, a_rot, 0, 0, 0, 0, 4'b1000, 4'b0100, 1, 64'hDEADBEEF_00000022);
    tbl[5]  = mk(4'b0001, a_rot, 0, 0, 0, 0, 4'b0001, 4'b1000, 1, 64'hDEADBEEF_00000023);
    tbl[6]  = mk(4'b0000, '0, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 64'hDEADBEEF_00000020);
    // single reader: port 2, addr 0x05
    tbl[7]  = mk(4'b0100, {7'h0, 7'h05, 7'h0, 7'h0}, 0, 0, 0, 0, 4'b0100, 4'b0000, 0, 0);
    tbl[8]  = mk(4'b0000, '0, 0, 0, 0, 0, 4'b0000, 4'b0100, 1, 64'hDEADBEEF_00000005);
    // refill beats a concurrent port-0 read of the same word
    tbl[9]  = mk(4'b0001, {21'h0, 7'h10}, 1, 7'h10, 64'h11223344_55667788, 8'hFF, 4'b0000, 4'b0000, 0, 0);
    tbl[10] = mk(4'b0001, {21'h0, 7'h10}, 0, 0, 0, 0, 4'b0001, 4'b0000, 0, 0);
    tbl[11] = mk(4'b0000, '0, 0, 0, 0, 0, 4'b0000, 4'b0001, 1, 64'h11223344_55667788);
    // partial refill: only low 4 bytes written
    tbl[12] = mk(4'b0000, '0, 1, 7'h11, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 4'b0000, 4'b0000, 0, 0);
    tbl[13] = mk(4'b1000, {7'h11, 21'h0}, 0, 0, 0, 0, 4'b1000, 4'b0000, 0, 0);
    // same port: new grant alongside its own rvalid
    tbl[14] = mk(4'b1000, {7'h12, 21'h0}, 0, 0, 0, 0, 4'b1000, 4'b1000, 1, 64'hDEADBEEF_BBBBBBBB);
    tbl[15] = mk(4'b0000, '0, 0, 0, 0, 0, 4'b0000, 4'b1000, 1, 64'hDEADBEEF_00000012);

    rst_n = 1'b0; rd_req_i = '0; rd_addr_i = '0; refill_req_i = 1'b0;
    refill_addr_i = '0; refill_wdata_i = '0; refill_be_i = '0;
    #3;
    check("reset rvalid", 64'(rd_rvalid_o), 64'h0);
    check("reset ram_req", 64'(ram_req_o), 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      rd_req_i = tbl[i].rd_req; rd_addr_i = tbl[i].addrs;
      refill_req_i = tbl[i].rf; refill_addr_i = tbl[i].rf_addr;
      refill_wdata_i = tbl[i].rf_wdata; refill_be_i = tbl[i].rf_be;
      #1;
      exp_addr = '0;
      for (int k = 0; k < 4; k++) if (tbl[i].exp_gnt[k]) exp_addr = tbl[i].addrs[k];
      if (tbl[i].rf) exp_addr = tbl[i].rf_addr;
      check($sformatf("row%0d rd_gnt", i), 64'(rd_gnt_o), 64'(tbl[i].exp_gnt));
      check($sformatf("row%0d refill_gnt", i), 64'(refill_gnt_o), 64'(tbl[i].rf));
      check($sformatf("row%0d rvalid", i), 64'(rd_rvalid_o), 64'(tbl[i].exp_rvalid));
      check($sformatf("row%0d ram_req", i), 64'(ram_req_o), 64'(tbl[i].rf || (tbl[i].exp_gnt != 0)));
      check($sformatf("row%0d ram_write", i), 64'(ram_write_o), 64'(tbl[i].rf));
      check($sformatf("row%0d ram_addr", i), 64'(ram_addr_o), 64'(exp_addr));
      check($sformatf("row%0d ram_wdata", i), ram_wdata_o, tbl[i].rf ? tbl[i].rf_wdata : 64'h0);
      check($sformatf("row%0d ram_be", i), 64'(ram_be_o),
            tbl[i].rf ? 64'(tbl[i].rf_be) : ((tbl[i].exp_gnt != 0) ? 64'hFF : 64'h0));
      if (tbl[i].chk_rdata)
        check($sformatf("row%0d rdata", i), rd_rdata_o, tbl[i].exp_rdata);
    end

    // Refill held high while port 1 waits.
    for (int c = 0; c < 7; c++) begin
      logic       exp_rf;
      logic [3:0] exp_g;
      @(posedge clk);
      #1;
      refill_addr_i = 7'h30; refill_wdata_i = '0; refill_be_i = 8'hFF;
      rd_addr_i = {7'h0, 7'h0, 7'h31, 7'h0};
`ifdef L15_REFILL_FAIRNESS_EN
      refill_req_i = (c < 6);
      rd_req_i     = (c <= 4) ? 4'b0010 : 4'b0000;
      exp_rf       = (c != 4) && (c < 6);
      exp_g        = (c == 4) ? 4'b0010 : 4'b0000;
`else
      refill_req_i = (c < 6);
      rd_req_i     = 4'b0010;
      exp_rf       = (c < 6);
      exp_g        = (c == 6) ? 4'b0010 : 4'b0000;
`endif
      #1;
      check($sformatf("fair%0d refill_gnt", c), 64'(refill_gnt_o), 64'(exp_rf));
      check($sformatf("fair%0d rd_gnt", c), 64'(rd_gnt_o), 64'(exp_g));
    end

    // Reset one cycle after a grant drops the in-flight rvalid and rr_q.
    @(posedge clk);
    #1 refill_req_i = 1'b0; rd_req_i = 4'b0001; rd_addr_i = {21'h0, 7'h05};
    #1 check("pre-reset rd_gnt", 64'(rd_gnt_o), 64'h1);
    @(posedge clk);
    #1 rst_n = 1'b0; rd_req_i = '0;
    #1 check("mid-reset rvalid", 64'(rd_rvalid_o), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1; rd_req_i = 4'b1111;
    #1 check("post-reset rr start", 64'(rd_gnt_o), 64'h1);
    @(posedge clk);
    #1 rd_req_i = '0;
    #1 check("post-reset rvalid", 64'(rd_rvalid_o), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
